// File: rtl/bin_to_seg_display.sv
// Sequential binary-to-7-segment encoder. A double-dabble engine converts one bit per clock.
// Each digit pattern is registered so the displays never show a partial result.

module bin_to_seg_digit (
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);
  // active-low, bit0=a ... bit6=g
  always_comb begin
    seg = 7'h7F;
    if (dash) begin
      seg = 7'h3F;
    end else if (!blank) begin
      unique case (digit)
        4'd0:    seg = 7'h40;
        4'd1:    seg = 7'h79;
        4'd2:    seg = 7'h24;
        4'd3:    seg = 7'h30;
        4'd4:    seg = 7'h19;
        4'd5:    seg = 7'h12;
        4'd6:    seg = 7'h02;
        4'd7:    seg = 7'h78;
        4'd8:    seg = 7'h00;
        4'd9:    seg = 7'h10;
        default: seg = 7'h7F;
      endcase
    end
  end
endmodule

module bin_to_seg_display #(
  parameter int N        = 7,
  parameter int M        = 6,
  parameter int W        = 20,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] value,
  output logic         busy,
  output logic         done,
  output logic         overflow,
  output logic [N-1:0] hex [M-1:0]
);
  localparam int          CW   = $clog2(W + 1);
  localparam logic [63:0] MAXV = 64'(10**M - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     bin_q;
  logic [4*M-1:0]   bcd_q, bcd_adj;
  logic [CW-1:0]    cnt_q;
  logic             ovf_pend_q;
  logic             load, shift, encode;
  logic [M-1:0]     blank;
  logic [M:1]       upz;
  logic [M-1:0][6:0] seg_w;

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CW'(1)) state_d = ENCODE;
      ENCODE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // control strobes
  always_comb begin
    load   = (state_q == IDLE) && start;
    shift  = (state_q == SHIFT);
    encode = (state_q == ENCODE);
  end

  // add-3 correction on every nibble before it is doubled
  for (genvar i = 0; i < M; i++) begin : g_adj
    assign bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                         : bcd_q[4*i +: 4];
  end

  // conversion datapath; carries out of the top digit are dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
    end else if (load) begin
      bin_q      <= value;
      bcd_q      <= '0;
      cnt_q      <= CW'(W);
      ovf_pend_q <= 64'(value) > MAXV;
    end else if (shift) begin
      {bcd_q, bin_q} <= {bcd_adj[4*M-2:0], bin_q, 1'b0};
      cnt_q          <= cnt_q - CW'(1);
    end
  end

  // upz[i]: digits i..M-1 are all zero
  assign upz[M]   = 1'b1;
  assign blank[0] = 1'b0;
  for (genvar i = 1; i < M; i++) begin : g_lz
    assign upz[i]   = upz[i+1] & (bcd_q[4*i +: 4] == 4'd0);
    assign blank[i] = BLANK_LZ & upz[i];
  end

  for (genvar i = 0; i < M; i++) begin : g_dig
    bin_to_seg_digit u_dig (
      .digit (bcd_q[4*i +: 4]),
      .blank (blank[i]),
      .dash  (ovf_pend_q),
      .seg   (seg_w[i])
    );
  end

  // registered outputs; hex/overflow only change on the ENCODE edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      for (int i = 0; i < M; i++) hex[i] <= '1;
    end else begin
      busy <= (state_d != IDLE);
      done <= encode;
      if (encode) begin
        overflow <= ovf_pend_q;
        for (int i = 0; i < M; i++) hex[i] <= seg_w[i];
      end
    end
  end
endmodule

// File: tb/tb_bin_to_seg_display.sv
// Scoreboard bench: drives two instances (leading-zero blanking on/off) with shared stimulus
// and checks every done against a decimal reference model.

module tb_bin_to_seg_display;
  localparam int N = 7, M = 6, W = 20;

  logic         clk = 1'b0, reset_n = 1'b1, start = 1'b0;
  logic [W-1:0] value = '0;
  logic         busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [N-1:0] hex_a [M-1:0];
  logic [N-1:0] hex_b [M-1:0];

  int checks = 0, errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  bin_to_seg_display #(.N(N), .M(M), .W(W), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .value(value),
    .busy(busy_a), .done(done_a), .overflow(ovf_a), .hex(hex_a));

  bin_to_seg_display #(.N(N), .M(M), .W(W), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .value(value),
    .busy(busy_b), .done(done_b), .overflow(ovf_b), .hex(hex_b));

  typedef struct packed {
    logic [M-1:0][6:0] ha;
    logic [M-1:0][6:0] hb;
    logic              ovf;
    logic [31:0]       v;
  } exp_t;

  exp_t q[$];

  function automatic logic [6:0] seg(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tbl[d];
  endfunction

  // decimal reference: digit i = (v / 10^i) % 10, blank if v < 10^i (i>0)
  function automatic exp_t model(input logic [31:0] v);
    exp_t   e;
    longint vl, p, lim;
    int     d;
    vl  = longint'({32'd0, v});
    lim = 1;
    for (int i = 0; i < M; i++) lim = lim * 10;
    e.v   = v;
    e.ovf = vl > lim - 1;
    p = 1;
    for (int i = 0; i < M; i++) begin
      d = int'((vl / p) % 10);
      if (e.ovf) begin
        e.ha[i] = 7'h3F;
        e.hb[i] = 7'h3F;
      end else begin
        e.hb[i] = seg(d);
        e.ha[i] = (i > 0 && vl < p) ? 7'h7F : seg(d);
      end
      p = p * 10;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic [M-1:0][6:0] disp_a = '1, disp_b = '1;
  logic              disp_ovf = 1'b0;
  logic              started = 1'b0, held_mode = 1'b0;
  int                brun = 0, last_done = -1;

  always @(negedge clk) begin
    logic [M-1:0][6:0] pa, pb;
    exp_t e;
    for (int i = 0; i < M; i++) begin
      pa[i] = hex_a[i];
      pb[i] = hex_b[i];
    end
    if (!reset_n) begin
      brun = 0;
      disp_a = '1; disp_b = '1; disp_ovf = 1'b0;
    end else if (started) begin
      if (busy_a) brun++;
      else begin
        if (brun != 0) chk("busy_len", 64'(brun), 64'(W + 1));
        brun = 0;
      end
      chk("busy_match", 64'(busy_b), 64'(busy_a));
      if (done_a || done_b) begin
        chk("done_pair", 64'(done_b), 64'(done_a));
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending conversion");
        end else begin
          e = q.pop_front();
          disp_a = e.ha; disp_b = e.hb; disp_ovf = e.ovf;
          if (held_mode) begin
            if (last_done >= 0) chk("done_period", 64'(cyc - last_done), 64'(W + 2));
            last_done = cyc;
          end
        end
      end
      chk("hex_blank_lz", 64'(pa), 64'(disp_a));
      chk("hex_all_digits", 64'(pb), 64'(disp_b));
      chk("overflow", {62'd0, ovf_b, ovf_a}, {62'd0, disp_ovf, disp_ovf});
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int n = 0;
    while (busy_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy_a) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", n);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || busy_a) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || busy_a) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results still pending, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic convert(input logic [31:0] v);
    wait_idle();
    value = v[W-1:0];
    start = 1'b1;
    q.push_back(model(32'(v[W-1:0])));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_reset_state(input string name);
    logic [M-1:0][6:0] pa;
    for (int i = 0; i < M; i++) pa[i] = hex_a[i];
    chk({name, "_hex"}, 64'(pa), {{(64-7*M){1'b0}}, {M{7'h7F}}});
    chk({name, "_ctl"}, {61'd0, busy_a, done_a, ovf_a}, 64'd0);
  endtask

  initial begin
    int r;
    logic [31:0] v;
    #2 reset_n = 1'b0;
    #1 chk_reset_state("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    started = 1'b1;

    // directed cases
    convert(123456);
    convert(0);
    convert(999999);
    convert(1000000);
    convert(7);
    drain();

    // start during a conversion is ignored
    convert(555555);
    repeat (4) @(negedge clk);
    value = 20'd111111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // reset mid-conversion: no done, display blanks
    convert(123456);
    drain();
    value = 20'd654321; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1 chk_reset_state("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    convert(42);
    drain();

    // start held high: accepted every W+2 edges
    wait_idle();
    held_mode = 1'b1; last_done = -1;
    value = 20'd100; start = 1'b1;
    for (int i = 0; i < 3; i++) q.push_back(model(32'd100));
    repeat (2 * (W + 2) + 1) @(negedge clk);
    start = 1'b0;
    drain();
    held_mode = 1'b0;

    // randomized values across the range, including overflow
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 3);
      case (r)
        0:       v = $urandom_range(0, 99);
        1:       v = $urandom_range(0, 999999);
        2:       v = $urandom_range(999990, 1048575);
        default: v = $urandom & 32'hF_FFFF;
      endcase
      convert(v);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
